// File: rtl/xbus_master_pkg.sv
// Shared XBUS configuration defaults, widths and access-alignment helper for xbus_master.
// Guarded defaults; an integration-level config.vh defining these macros takes precedence.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBUS_TIMEOUT
`define XBUS_TIMEOUT 16
`endif

package xbus_master_pkg;

   localparam int ADDR_W = `XADDRW;
   localparam int DATA_W = `XDATAW;
   localparam int CNT_W  = 8;

   // Word accesses need addr[1:0]==0; halfword lanes (0011/1100) need an even address.
   function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
      logic word_bad;
      logic half_bad;
      word_bad = (be == 4'b1111) && (addr_lo != 2'b00);
      half_bad = ((be == 4'b0011) || (be == 4'b1100)) && addr_lo[0];
      return word_bad || half_bad;
   endfunction

endpackage

// File: rtl/xbus_master.sv
// Sole XBUS initiator: turns a single-outstanding core access into one bus cycle,
// with a no-ready timeout and up-front rejection of misaligned accesses.
module xbus_master
   import xbus_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = `XBUS_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [`XADDRW-1:0] cpu_addr,
   input  logic [`XDATAW-1:0] cpu_wdata,
   input  logic [3:0]         cpu_be,
   output logic               cpu_busy,
   output logic               cpu_ack,
   output logic               cpu_err,
   output logic [`XDATAW-1:0] cpu_rdata,
   output logic               xbus_as,
   output logic [`XADDRW-1:0] xbus_addr,
   output logic               xbus_we,
   output logic [`XDATAW-1:0] xbus_wdata,
   output logic [3:0]         xbus_be,
   input  logic               xbus_rdy,
   input  logic [`XDATAW-1:0] xbus_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUS  = BUS,
      ST_RESP = RESP
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               err_reg, err_next;
   logic [`XDATAW-1:0] rdata_reg, rdata_next;
   logic [`XADDRW-1:0] addr_reg, addr_next;
   logic               we_reg, we_next;
   logic [`XDATAW-1:0] wdata_reg, wdata_next;
   logic [3:0]         be_reg, be_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         rdata_reg <= '0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         wdata_reg <= '0;
         be_reg    <= '0;
      end else begin
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         rdata_reg <= rdata_next;
         addr_reg  <= addr_next;
         we_reg    <= we_next;
         wdata_reg <= wdata_next;
         be_reg    <= be_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      rdata_next = rdata_reg;
      addr_next  = addr_reg;
      we_next    = we_reg;
      wdata_next = wdata_reg;
      be_next    = be_reg;

      case (state_reg)
         ST_IDLE: begin
            if (cpu_req) begin
               if (is_misaligned(cpu_be, cpu_addr[1:0])) begin
                  err_next   = 1'b1;
                  state_next = ST_RESP;
               end else begin
                  addr_next  = cpu_addr;
                  we_next    = cpu_we;
                  wdata_next = cpu_wdata;
                  be_next    = cpu_be;
                  cnt_next   = '0;
                  state_next = ST_BUS;
               end
            end
         end
         ST_BUS: begin
            // Ready is checked first so a late slave beats the timeout in the same cycle.
            if (xbus_rdy) begin
               if (!we_reg) begin
                  rdata_next = xbus_rdata;
               end
               err_next   = 1'b0;
               state_next = ST_RESP;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               err_next   = 1'b1;
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign xbus_as    = (state_reg == ST_BUS);
   assign cpu_ack    = (state_reg == ST_RESP);
   assign cpu_busy   = (state_reg != ST_IDLE);
   assign cpu_err    = cpu_ack & err_reg;
   assign cpu_rdata  = rdata_reg;
   assign xbus_addr  = addr_reg;
   assign xbus_we    = we_reg;
   assign xbus_wdata = wdata_reg;
   assign xbus_be    = be_reg;

endmodule

// File: tb/tb_xbus_master.sv
// Directed bench for xbus_master: single reads/writes, waits, timeout, alignment and reset abort.
module tb_xbus_master;
   import xbus_master_pkg::*;

   localparam int unsigned TMO = 16;

   logic              clk;
   logic              rst_n;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [3:0]        cpu_be;
   logic              cpu_busy;
   logic              cpu_ack;
   logic              cpu_err;
   logic [DATA_W-1:0] cpu_rdata;
   logic              xbus_as;
   logic [ADDR_W-1:0] xbus_addr;
   logic              xbus_we;
   logic [DATA_W-1:0] xbus_wdata;
   logic [3:0]        xbus_be;
   logic              xbus_rdy;
   logic [DATA_W-1:0] xbus_rdata;

   int n_cmp = 0;
   int n_err = 0;

   xbus_master #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_be     (cpu_be),
      .cpu_busy   (cpu_busy),
      .cpu_ack    (cpu_ack),
      .cpu_err    (cpu_err),
      .cpu_rdata  (cpu_rdata),
      .xbus_as    (xbus_as),
      .xbus_addr  (xbus_addr),
      .xbus_we    (xbus_we),
      .xbus_wdata (xbus_wdata),
      .xbus_be    (xbus_be),
      .xbus_rdy   (xbus_rdy),
      .xbus_rdata (xbus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      cpu_be    = be;
   endtask

   initial begin
      rst_n      = 1'b0;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      cpu_be     = '0;
      xbus_rdy   = 1'b0;
      xbus_rdata = '0;

      // Reset values
      #12;
      chk("rst_as", 64'(xbus_as), 64'd0);
      chk("rst_ack", 64'(cpu_ack), 64'd0);
      chk("rst_err", 64'(cpu_err), 64'd0);
      chk("rst_busy", 64'(cpu_busy), 64'd0);
      chk("rst_we", 64'(xbus_we), 64'd0);
      chk("rst_addr", 64'(xbus_addr), 64'd0);
      chk("rst_wdata", 64'(xbus_wdata), 64'd0);
      chk("rst_be", 64'(xbus_be), 64'd0);
      chk("rst_rdata", 64'(cpu_rdata), 64'd0);
      cyc();
      rst_n = 1'b1;

      // Zero-wait read from 0x80000004
      req(1'b0, 32'h8000_0004, 32'h0, 4'hF);
      cyc();
      $display("read 80000004 zero-wait");
      cpu_req = 1'b0;
      chk("t1_c1_as", 64'(xbus_as), 64'd1);
      chk("t1_c1_busy", 64'(cpu_busy), 64'd1);
      chk("t1_c1_addr", 64'(xbus_addr), 64'h8000_0004);
      chk("t1_c1_ack", 64'(cpu_ack), 64'd0);
      xbus_rdy   = 1'b1;
      xbus_rdata = 32'hDEAD_BEEF;
      cyc();
      xbus_rdy = 1'b0;
      chk("t1_c2_ack", 64'(cpu_ack), 64'd1);
      chk("t1_c2_err", 64'(cpu_err), 64'd0);
      chk("t1_c2_as", 64'(xbus_as), 64'd0);
      chk("t1_c2_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
      // A request raised during the ack cycle must be ignored
      req(1'b0, 32'h8000_0008, 32'h0, 4'hF);
      cyc();
      cpu_req = 1'b0;
      chk("t1_c3_ack", 64'(cpu_ack), 64'd0);
      chk("t1_c3_busy", 64'(cpu_busy), 64'd0);
      cyc();
      chk("t1_c4_busy", 64'(cpu_busy), 64'd0);

      // Write with ready in cycle 4
      req(1'b1, 32'h1000_0000, 32'h1234_5678, 4'hF);
      $display("write 10000000 ready in cycle 4");
      for (int c = 1; c <= 4; c++) begin
         cyc();
         cpu_req  = 1'b0;
         cpu_addr = 32'hFFFF_FFFF;
         chk($sformatf("t2_c%0d_as", c), 64'(xbus_as), 64'd1);
         chk($sformatf("t2_c%0d_addr", c), 64'(xbus_addr), 64'h1000_0000);
         chk($sformatf("t2_c%0d_wdata", c), 64'(xbus_wdata), 64'h1234_5678);
         chk($sformatf("t2_c%0d_be", c), 64'(xbus_be), 64'hF);
         chk($sformatf("t2_c%0d_we", c), 64'(xbus_we), 64'd1);
         chk($sformatf("t2_c%0d_ack", c), 64'(cpu_ack), 64'd0);
      end
      xbus_rdy   = 1'b1;
      xbus_rdata = 32'h0BAD_0BAD;
      cyc();
      xbus_rdy = 1'b0;
      chk("t2_c5_ack", 64'(cpu_ack), 64'd1);
      chk("t2_c5_err", 64'(cpu_err), 64'd0);
      chk("t2_c5_rdata_kept", 64'(cpu_rdata), 64'hDEAD_BEEF);
      chk("t2_c5_addr_held", 64'(xbus_addr), 64'h1000_0000);
      cyc();

      // Timeout on unmapped 0x20000000
      req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
      $display("read 20000000 timeout");
      for (int c = 1; c <= int'(TMO); c++) begin
         cyc();
         cpu_req = 1'b0;
         chk($sformatf("t3_c%0d_as", c), 64'(xbus_as), 64'd1);
         chk($sformatf("t3_c%0d_ack", c), 64'(cpu_ack), 64'd0);
      end
      cyc();
      chk("t3_ack", 64'(cpu_ack), 64'd1);
      chk("t3_err", 64'(cpu_err), 64'd1);
      chk("t3_as", 64'(xbus_as), 64'd0);
      chk("t3_rdata_kept", 64'(cpu_rdata), 64'hDEAD_BEEF);
      cyc();

      // Misaligned word read
      req(1'b0, 32'h8000_0002, 32'h0, 4'hF);
      $display("word read 80000002 misaligned");
      cyc();
      cpu_req = 1'b0;
      chk("t4_ack", 64'(cpu_ack), 64'd1);
      chk("t4_err", 64'(cpu_err), 64'd1);
      chk("t4_as", 64'(xbus_as), 64'd0);
      chk("t4_addr_untouched", 64'(xbus_addr), 64'h2000_0000);
      cyc();
      chk("t4_c2_ack", 64'(cpu_ack), 64'd0);

      // Misaligned low halfword at an odd address
      req(1'b0, 32'h8000_0001, 32'h0, 4'h3);
      $display("half read 80000001 misaligned");
      cyc();
      cpu_req = 1'b0;
      chk("t4b_ack", 64'(cpu_ack), 64'd1);
      chk("t4b_err", 64'(cpu_err), 64'd1);
      chk("t4b_as", 64'(xbus_as), 64'd0);
      cyc();

      // Aligned upper halfword at 0x80000002
      req(1'b0, 32'h8000_0002, 32'h0, 4'hC);
      $display("half read 80000002 be=1100");
      cyc();
      cpu_req = 1'b0;
      chk("t4c_as", 64'(xbus_as), 64'd1);
      chk("t4c_addr", 64'(xbus_addr), 64'h8000_0002);
      chk("t4c_be", 64'(xbus_be), 64'hC);
      xbus_rdy   = 1'b1;
      xbus_rdata = 32'hCAFE_F00D;
      cyc();
      xbus_rdy = 1'b0;
      chk("t4c_ack", 64'(cpu_ack), 64'd1);
      chk("t4c_err", 64'(cpu_err), 64'd0);
      chk("t4c_rdata", 64'(cpu_rdata), 64'hCAFE_F00D);
      cyc();

      // Ready arrives in the last counted cycle: ready wins over timeout
      req(1'b0, 32'h8000_0010, 32'h0, 4'hF);
      $display("read 80000010 ready at timeout edge");
      for (int c = 1; c <= int'(TMO); c++) begin
         cyc();
         cpu_req = 1'b0;
      end
      chk("t5_as_last", 64'(xbus_as), 64'd1);
      xbus_rdy   = 1'b1;
      xbus_rdata = 32'h5A5A_1234;
      cyc();
      xbus_rdy = 1'b0;
      chk("t5_ack", 64'(cpu_ack), 64'd1);
      chk("t5_err", 64'(cpu_err), 64'd0);
      chk("t5_rdata", 64'(cpu_rdata), 64'h5A5A_1234);
      cyc();

      // Reset dropped in cycle 3 of a waited read
      req(1'b0, 32'h8000_0020, 32'h0, 4'hF);
      $display("read 80000020 aborted by reset");
      cyc();
      cpu_req = 1'b0;
      cyc();
      cyc();
      chk("t6_as_before", 64'(xbus_as), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_as_async", 64'(xbus_as), 64'd0);
      chk("t6_busy_async", 64'(cpu_busy), 64'd0);
      chk("t6_ack_async", 64'(cpu_ack), 64'd0);
      cyc();
      chk("t6_ack_hold", 64'(cpu_ack), 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("t6_ack_after", 64'(cpu_ack), 64'd0);
      chk("t6_busy_after", 64'(cpu_busy), 64'd0);

      // Normal access after reset release
      req(1'b0, 32'h8000_0024, 32'h0, 4'hF);
      $display("read 80000024 after reset");
      cyc();
      cpu_req = 1'b0;
      chk("t7_as", 64'(xbus_as), 64'd1);
      xbus_rdy   = 1'b1;
      xbus_rdata = 32'h7777_0001;
      cyc();
      xbus_rdy = 1'b0;
      chk("t7_ack", 64'(cpu_ack), 64'd1);
      chk("t7_err", 64'(cpu_err), 64'd0);
      chk("t7_rdata", 64'(cpu_rdata), 64'h7777_0001);
      cyc();
      chk("t7_idle", 64'(cpu_busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xbus_master.md
# xbus_master

Bridges the core's single-outstanding memory port onto the XBUS as the sole bus initiator. It is the counterpart to the address decoder: it drives address strobe, address, direction, write data and byte enables, then waits for the selected slave's ready. It returns read data or a bus error to the core. Unmapped addresses are caught by a timeout, and misaligned word accesses are rejected without a bus cycle.

## Interface
Parameters:
- TIMEOUT, 16: cycles with `xbus_as` high and no `xbus_rdy` before the access is aborted with an error; legal range 2..255.

Ports (clock and reset first):
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  `XADDRW  byte address.
- cpu_wdata  in  `XDATAW  write data.
- cpu_be  in  4  byte enables; 4'b1111 = word.
- cpu_busy  out  1  high in any state other than IDLE.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with `cpu_ack`; 1 = timeout or misaligned access.
- cpu_rdata  out  `XDATAW  read data; valid with `cpu_ack` on a successful read, otherwise holds its old value.
- xbus_as  out  1  address strobe; feeds the decoder.
- xbus_addr  out  `XADDRW  registered address.
- xbus_we  out  1  registered direction.
- xbus_wdata  out  `XDATAW  registered write data.
- xbus_be  out  4  registered byte enables.
- xbus_rdy  in  1  OR of slave ready signals, gated by chip select.
- xbus_rdata  in  `XDATAW  muxed slave read data.

## Operation
- States: IDLE, BUS, RESP.
- IDLE, `cpu_req`=0: stay in IDLE.
- IDLE, `cpu_req`=1, misaligned: go to RESP with err=1. Misaligned means `cpu_be`=1111 with addr[1:0]≠0, or `cpu_be`=0011/1100 with addr[0]≠0. No bus cycle is issued.
- IDLE, `cpu_req`=1, aligned: latch addr/we/wdata/be into the `xbus_*` registers, clear the counter, go to BUS.
- BUS: `xbus_as`=1.
  - `xbus_rdy`=1: capture `xbus_rdata` (reads only), set err=0, go to RESP.
  - Otherwise, when the counter equals TIMEOUT-1: set err=1 and go to RESP.
  - Otherwise: increment the counter.
  - If `xbus_rdy` and the timeout coincide in the same cycle, `xbus_rdy` wins (err=0).
- RESP: `cpu_ack`=1 for exactly one cycle, then go to IDLE. A `cpu_req` present in RESP is ignored.
- Counter: 8 bits; saturation is never reached because TIMEOUT ≤ 255.
- The `xbus_*` address, direction, data and byte-enable registers stay stable for the entire BUS phase and hold their values after it ends.
- Reset mid-access: return to IDLE immediately with `xbus_as`=0; no `cpu_ack` is produced for the aborted access.

## Timing
- Reset values: state=IDLE; `xbus_as`, `xbus_we`, `cpu_ack`, `cpu_err`, `cpu_busy` = 0; `xbus_addr`, `xbus_wdata`, `cpu_rdata` = 0; `xbus_be` = 0.
- Cycle 0: `cpu_req` sampled in IDLE. Cycle 1: `xbus_as`=1 with all `xbus_*` outputs valid.
- If `xbus_rdy` is first high in cycle k ≥ 1, `cpu_ack` is high in cycle k+1 and `xbus_as` is 0 in cycle k+1.
- Zero-wait slave (ready in cycle 1): ack in cycle 2, so 3 cycles per access.
- Timeout: `xbus_as` is high for cycles 1..TIMEOUT, and ack/err appear in cycle TIMEOUT+1.
- Misaligned access: ack/err in cycle 1; `xbus_as` never rises.
- Back-to-back: the earliest next `cpu_req` acceptance is the cycle after the ack (IDLE).
- `cpu_busy` is registered-state-derived (state ≠ IDLE); it is 0 in IDLE.

## Structure
- `config.vh` supplies `XADDRW` and `XDATAW`.
- Add `XBUS_TIMEOUT` to `config.vh` as the default for TIMEOUT.
- State encodings are local `localparam`s: IDLE=2'd0, BUS=2'd1, RESP=2'd2.
- Single flat module; no sub-module is warranted.
- Integration: `xbus_as` and `xbus_addr` feed `xbus_decoder`. The top level ORs slave ready signals and muxes `xbus_rdata` by the decoder's chip selects.

## Test plan
- Read from 0x80000004; slave asserts rdy in cycle 1 with 0xDEADBEEF -> `xbus_as` high in cycle 1 only, ack in cycle 2 with err=0 and `cpu_rdata`=0xDEADBEEF.
- Write 0x12345678, be=1111, to 0x10000000; rdy delayed to cycle 4 -> `xbus_addr`/`xbus_wdata`/`xbus_be`/`xbus_we`=1 stable in cycles 1–4, ack in cycle 5, err=0.
- Read from unmapped 0x20000000 with TIMEOUT=16 and rdy never asserted -> `xbus_as` high in cycles 1–16, ack with err=1 in cycle 17, `cpu_rdata` unchanged.
- Word read at 0x80000002 -> ack with err=1 in cycle 1, `xbus_as` never asserted. Halfword (be=1100) at 0x80000002 -> normal bus access.
- rdy rises in the exact cycle the counter equals TIMEOUT-1 -> ack with err=0 and data captured.
- `rst_n` dropped in cycle 3 of a waited read -> `xbus_as`=0 and `cpu_busy`=0 immediately, no ack. The next request after release completes normally.
